pwm_output_stage: RTL and testbench
===================================

Name: pwm_output_stage

Overview:
Downstream consumer of the SPI register file. It takes the five configuration registers (output enables, PWM enables, duty cycle) and drives the 16 chip outputs. Each output is forced low, forced high, or driven by a shared ~3 kHz PWM waveform (10 MHz clk). Duty updates are applied only at period boundaries, so a mid-period SPI write never glitches the waveform.

Parameters:
CLK_DIV, 13, clk cycles per PWM step (≥1); period = 256*CLK_DIV clk cycles (3328 by default).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en_reg_out_7_0  input  8  output enable, bits 7:0
en_reg_out_15_8  input  8  output enable, bits 15:8
en_reg_pwm_7_0  input  8  PWM mode select, bits 7:0
en_reg_pwm_15_8  input  8  PWM mode select, bits 15:8
pwm_duty_cycle  input  8  duty value, 0x00 = 0 %, 0xFF = 100 %
out  output  16  registered output pins; out[7:0] feed uo_out, out[15:8] feed uio_out
period_start  output  1  single-cycle pulse on the first clk of each PWM period

Behaviour:
- Reset (rst_n low, asynchronous): prescaler=0, step counter=0, duty_shadow=0x00, out=0x0000, period_start=0.
- Prescaler counts 0..CLK_DIV-1 and wraps. When the prescaler equals CLK_DIV-1, the 8-bit step counter increments; 255 wraps to 0.
- Period start is the cycle where prescaler==0 and step==0. This includes the first cycle after reset release.
- At period start:
  - duty_shadow <= pwm_duty_cycle.
  - The effective duty for that cycle is the new pwm_duty_cycle (bypass), not the old shadow.
- Effective duty is the bypass value at period start and duty_shadow otherwise. pwm_level = 1 if effective duty == 0xFF, else (step < effective duty).
  - High time per period = duty*CLK_DIV cycles.
  - Duty 0x00 gives constantly low; duty 0xFF gives constantly high.
- Per bit i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - en_out[i]=0 → out[i] <= 0, regardless of en_pwm[i].
  - en_out[i]=1, en_pwm[i]=0 → out[i] <= 1.
  - en_out[i]=1, en_pwm[i]=1 → out[i] <= pwm_level.
- Latency: out is registered, so it reflects the enables and pwm_level of the previous clk.
  - Enable changes take effect 1 clk later, mid-period allowed.
  - Duty changes take effect at the next period start only.
- period_start is registered: it is high for exactly one clk, one cycle after the internal period-start condition, aligned with the out update for step 0.
- All inputs are treated as synchronous to clk: the SPI block produces them from the same clk, so no resynchronisation is added here.
- Duty written several times within one period: only the value present at the next period start is used.
- Reset asserted mid-period: all state clears immediately. The timebase restarts from step 0 after release, with no partial-period carryover.
- CLK_DIV=1: step advances every clk, period = 256 clk.

Decomposition:
- Shared package (spi_regs_pkg): constant PWM_STEPS=256; constant DUTY_FULL=8'hFF; register address constants 0x00–0x04, shared with the SPI block.
- Sub-module pwm_timebase: prescaler plus step counter. Outputs step[7:0] and a period_start_comb strobe.
- Top level holds duty_shadow, the compare, and the 16-bit output mux/register.

Test Plan:
- Reset then all registers 0 → out=0x0000 for ≥2 periods; period_start pulses every 3328 clk.
- en_out=0xFFFF, en_pwm=0x0000 → out=0xFFFF one clk after the enables apply; stays constant across periods.
- en_out=0x0001, en_pwm=0x0001, duty=0x80 → out[0] high for 128*13=1664 clk and low for 1664 per 3328-clk period; all other bits 0.
- duty=0x00 → out[0] never high; duty=0xFF → out[0] never low, over ≥3 periods.
- Duty changes 0x40→0xC0 at step 100 → current period keeps a 64*13=832-clk high time; the next period has 192*13=2496 clk high, starting with period_start.
- rst_n pulsed low at step 150 → out=0 asynchronously; after release, first period_start within 1 clk, full 3328-clk periods follow; en_out=0x8000, en_pwm=0 → out=0x8000.

Source files
------------

// File: rtl/spi_regs_pkg.sv
// Constants shared between the SPI register file and the PWM output stage.
package spi_regs_pkg;

  localparam int         PWM_STEPS = 256;
  localparam logic [7:0] DUTY_FULL = 8'hFF;

  localparam logic [7:0] ADDR_EN_OUT_7_0  = 8'h00;
  localparam logic [7:0] ADDR_EN_OUT_15_8 = 8'h01;
  localparam logic [7:0] ADDR_EN_PWM_7_0  = 8'h02;
  localparam logic [7:0] ADDR_EN_PWM_15_8 = 8'h03;
  localparam logic [7:0] ADDR_PWM_DUTY    = 8'h04;

  // Full-scale duty is forced high so 0xFF means a true 100 % output.
  function automatic logic pwm_compare(input logic [7:0] step, input logic [7:0] duty);
    return (duty == DUTY_FULL) || (step < duty);
  endfunction

endpackage

// File: rtl/pwm_output_stage_timebase.sv
// PWM timebase: clock prescaler plus 8-bit step counter, with a strobe
// marking the first clk of every PWM period.
module pwm_timebase
  import spi_regs_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] step,
  output logic       period_start_comb
);

  localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [7:0]    STEP_LAST  = 8'(PWM_STEPS - 1);

  logic [PW-1:0] r_presc;
  logic [7:0]    r_step;
  logic          w_presc_last;

  assign w_presc_last = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_step  <= '0;
    end else begin
      r_presc <= w_presc_last ? '0 : r_presc + PW'(1);
      if (w_presc_last) begin
        r_step <= (r_step == STEP_LAST) ? 8'd0 : r_step + 8'd1;
      end
    end
  end

  assign step              = r_step;
  assign period_start_comb = (r_presc == '0) && (r_step == 8'd0);

endmodule

// File: rtl/pwm_output_stage.sv
// Drives the 16 chip outputs low, high or from a shared PWM waveform; the
// duty value is sampled only at period boundaries so writes never glitch.
module pwm_output_stage
  import spi_regs_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic [7:0]  w_step;
  logic        w_period_start_comb;
  logic [7:0]  r_duty_shadow;
  logic [7:0]  w_duty_eff;
  logic        w_pwm_level;
  logic [15:0] w_en_out;
  logic [15:0] w_en_pwm;
  logic [15:0] w_out_next;

  pwm_timebase #(
    .CLK_DIV(CLK_DIV)
  ) u_timebase (
    .clk              (clk),
    .rst_n            (rst_n),
    .step             (w_step),
    .period_start_comb(w_period_start_comb)
  );

  // Bypass the shadow on the boundary cycle so step 0 already uses the new duty.
  assign w_duty_eff  = w_period_start_comb ? pwm_duty_cycle : r_duty_shadow;
  assign w_pwm_level = pwm_compare(w_step, w_duty_eff);

  assign w_en_out   = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign w_out_next = w_en_out & (~w_en_pwm | {16{w_pwm_level}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_shadow <= 8'h00;
      out           <= 16'h0000;
      period_start  <= 1'b0;
    end else begin
      if (w_period_start_comb) begin
        r_duty_shadow <= pwm_duty_cycle;
      end
      out          <= w_out_next;
      period_start <= w_period_start_comb;
    end
  end

endmodule

// File: tb/tb_pwm_output_stage.sv
// Scoreboard bench for pwm_output_stage: a time-based reference model queues
// the expected pins for every clk, and a monitor compares them.
module tb_pwm_output_stage;

  localparam int CLK_DIV = 13;
  localparam int PERIOD  = 256 * CLK_DIV;

  typedef struct packed {
    logic [15:0] o;
    logic        ps;
  } exp_t;

  logic        clk = 1'b1;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        period_start;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int         t;
  logic [7:0] m_shadow;

  int hi_cnt  = 0;
  int len_cnt = 0;
  int last_hi = -1;
  int last_len = -1;

  always #50 clk = ~clk;

  pwm_output_stage #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_out[7:0]),
    .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0 (en_pwm[7:0]),
    .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle (duty),
    .out            (out),
    .period_start   (period_start)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the timebase is pure arithmetic on clks since reset release.
  task automatic cycle();
    exp_t e;
    int   st;
    logic lvl;
    if (!rst_n) begin
      e.o      = 16'h0000;
      e.ps     = 1'b0;
      t        = 0;
      m_shadow = 8'h00;
    end else begin
      st = (t / CLK_DIV) % 256;
      if (t % PERIOD == 0) m_shadow = duty;
      lvl = (m_shadow == 8'hFF) || (st < int'(m_shadow));
      for (int i = 0; i < 16; i++) begin
        e.o[i] = en_out[i] ? (en_pwm[i] ? lvl : 1'b1) : 1'b0;
      end
      e.ps = (t % PERIOD == 0);
      t++;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic align();
    while (t % PERIOD != 0) cycle();
  endtask

  task automatic run_periods(input int n);
    align();
    repeat (n * PERIOD + 2) cycle();
  endtask

  // Monitor
  initial begin
    exp_t e;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: got empty queue expected an entry (time %0t)", $time);
      end else begin
        e = q.pop_front();
        chk("out", 32'(out), 32'(e.o));
        chk("period_start", 32'(period_start), 32'(e.ps));
      end
      if (period_start) begin
        last_hi  = hi_cnt;
        last_len = len_cnt;
        hi_cnt   = int'(out[0]);
        len_cnt  = 1;
      end else begin
        hi_cnt  += int'(out[0]);
        len_cnt += 1;
      end
    end
  end

  // Stimulus
  initial begin
    rst_n    = 1'b0;
    en_out   = 16'h0000;
    en_pwm   = 16'h0000;
    duty     = 8'h00;
    t        = 0;
    m_shadow = 8'h00;
    @(negedge clk);
    repeat (3) cycle();
    rst_n = 1'b1;

    repeat (2 * PERIOD + 2) cycle();
    chk("idle_period_len", 32'(last_len), 32'(PERIOD));
    chk("idle_high", 32'(last_hi), 32'd0);

    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    repeat (500) cycle();
    chk("all_forced_high", 32'(out), 32'h0000FFFF);

    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h80;
    run_periods(2);
    chk("duty80_high", 32'(last_hi), 32'(128 * CLK_DIV));
    chk("duty80_len", 32'(last_len), 32'(PERIOD));

    duty = 8'h00;
    run_periods(3);
    chk("duty00_high", 32'(last_hi), 32'd0);

    duty = 8'hFF;
    run_periods(3);
    chk("dutyFF_high", 32'(last_hi), 32'(PERIOD));

    duty = 8'h40;
    align();
    repeat (100 * CLK_DIV) cycle();
    duty = 8'hC0;
    repeat (PERIOD - 100 * CLK_DIV + 2) cycle();
    chk("duty40_kept", 32'(last_hi), 32'(64 * CLK_DIV));
    repeat (PERIOD) cycle();
    chk("dutyC0_next", 32'(last_hi), 32'(192 * CLK_DIV));

    for (int k = 0; k < 40; k++) begin
      en_out = 16'($urandom);
      en_pwm = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       duty = 8'h00;
        1:       duty = 8'hFF;
        default: duty = 8'($urandom);
      endcase
      repeat ($urandom_range(20, 400)) cycle();
    end

    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'hC8;
    align();
    repeat (150 * CLK_DIV) cycle();
    chk("pre_reset_high", 32'(out), 32'h00000001);
    rst_n = 1'b0;
    #5;
    chk("async_reset_out", 32'(out), 32'h0);
    chk("async_reset_ps", 32'(period_start), 32'h0);
    cycle();
    cycle();
    en_out = 16'h8000;
    en_pwm = 16'h0000;
    rst_n  = 1'b1;
    repeat (2 * PERIOD + 2) cycle();
    chk("post_reset_len", 32'(last_len), 32'(PERIOD));
    chk("post_reset_out", 32'(out), 32'h00008000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
